counter16_timer_ctrl: RTL and testbench

Interval-timer controller that sequences one `counter16` instance, the 16-bit synchronous counter built from four LS163 stages. It drives the counter's clear, load and enable pins, latches a programmable period and a 4-bit start phase, and detects terminal count on the counter output. It emits a one-cycle `TICK` per period, in one-shot or periodic mode. It sits between the host control registers and the counter.

---
 rtl/counter16_timer_ctrl.sv | 131 +++++++++++++
 tb/tb_counter16_timer_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/counter16_timer_ctrl.sv
// Interval-timer controller for an external counter16 (four LS163 stages).
// Arms the counter with a start phase, detects terminal count and emits TICK pulses.
module counter16_timer_ctrl (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        START,
    input  logic        STOP,
    input  logic        HOLD,
    input  logic        MODE,
    input  logic [15:0] PERIOD,
    input  logic [3:0]  PHASE,
    input  logic [15:0] CNT_Q,
    output logic        CNT_nCLR,
    output logic        CNT_nLOAD,
    output logic        CNT_ENP,
    output logic        CNT_ENT,
    output logic [3:0]  CNT_Din,
    output logic        TICK,
    output logic        BUSY,
    output logic        DONE,
    output logic [7:0]  TICKS
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] period_q;
    logic [3:0]  phase_q;
    logic        mode_q;
    logic        tick_q;
    logic        busy_q;
    logic        done_q;
    logic [7:0]  ticks_q;

    logic [15:0] term;
    logic        term_hit;
    logic        abort;
    logic        arm;
    logic        tick_d;

    // Wrapping subtraction makes PERIOD=0 behave as a 65536-cycle period.
    assign term     = period_q - 16'd1;
    assign term_hit = (state_q == ST_RUN) && (CNT_Q == term) && !HOLD;
    assign abort    = STOP && (state_q != ST_IDLE);
    assign tick_d   = term_hit && !STOP;

    // NOTE: every signal assigned in always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        arm     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START && !STOP) begin
                    state_d = ST_ARM;
                    arm     = 1'b1;
                end
            end
            ST_ARM: begin
                state_d = STOP ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                if (STOP) begin
                    state_d = ST_IDLE;
                end else if (term_hit && !mode_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (STOP) begin
                    state_d = ST_IDLE;
                end else if (START) begin
                    state_d = ST_ARM;
                    arm     = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q  <= ST_IDLE;
            period_q <= 16'h0000;
            phase_q  <= 4'h0;
            mode_q   <= 1'b0;
            tick_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ticks_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            if (arm) begin
                period_q <= PERIOD;
                phase_q  <= PHASE;
                mode_q   <= MODE;
            end
            tick_q <= tick_d;
            busy_q <= (state_d == ST_ARM) || (state_d == ST_RUN);
            done_q <= (state_d == ST_DONE);
            if (arm) begin
                ticks_q <= 8'h00;
            end else if (tick_d && (ticks_q != 8'hFF)) begin
                ticks_q <= ticks_q + 8'd1;
            end
        end
    end

    // Counter pin decode; clear overrides load and count inside the LS163 chain.
    always_comb begin
        CNT_nCLR  = !(CLR || abort || term_hit);
        CNT_nLOAD = !(!CLR && (state_q == ST_ARM));
        CNT_ENT   = !CLR && (state_q == ST_RUN);
        CNT_ENP   = CNT_ENT && !HOLD;
        CNT_Din   = CLR ? 4'h0 : phase_q;
    end

    assign TICK  = tick_q;
    assign BUSY  = busy_q;
    assign DONE  = done_q;
    assign TICKS = ticks_q;

endmodule

// File: tb/tb_counter16_timer_ctrl.sv
// Directed bench for counter16_timer_ctrl with a behavioural counter16 in the loop.
module tb_counter16_timer_ctrl;

    logic        clk = 1'b0;
    logic        clr, start, stop, hold, mode;
    logic [15:0] period;
    logic [3:0]  phase;
    logic [15:0] cnt_q;
    logic        cnt_nclr, cnt_nload, cnt_enp, cnt_ent;
    logic [3:0]  cnt_din;
    logic        tick, busy, done;
    logic [7:0]  ticks;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    counter16_timer_ctrl dut (
        .CLK      (clk),
        .CLR      (clr),
        .START    (start),
        .STOP     (stop),
        .HOLD     (hold),
        .MODE     (mode),
        .PERIOD   (period),
        .PHASE    (phase),
        .CNT_Q    (cnt_q),
        .CNT_nCLR (cnt_nclr),
        .CNT_nLOAD(cnt_nload),
        .CNT_ENP  (cnt_enp),
        .CNT_ENT  (cnt_ent),
        .CNT_Din  (cnt_din),
        .TICK     (tick),
        .BUSY     (busy),
        .DONE     (done),
        .TICKS    (ticks)
    );

    // counter16 model: clear beats load beats count; load zero-fills the upper bits.
    always_ff @(posedge clk) begin
        if (!cnt_nclr)                cnt_q <= 16'h0000;
        else if (!cnt_nload)          cnt_q <= {12'h000, cnt_din};
        else if (cnt_enp && cnt_ent)  cnt_q <= cnt_q + 16'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic saw_tick;

        clr = 1'b1; start = 1'b0; stop = 1'b0; hold = 1'b0; mode = 1'b0;
        period = 16'd0; phase = 4'd0;
        step();
        check("init_cnt", cnt_q, 16'h0000);
        clr = 1'b0;

        // Reset with the counter nonzero
        period = 16'd10; phase = 4'd3; mode = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("pre_rst_load", cnt_q, 16'd3);
        step();
        check("pre_rst_cnt", cnt_q, 16'd4);
        clr = 1'b1;
        #1;
        check("rst_nclr", cnt_nclr, 1'b0);
        check("rst_nload", cnt_nload, 1'b1);
        check("rst_enables", {cnt_enp, cnt_ent}, 2'b00);
        check("rst_din", cnt_din, 4'h0);
        step();
        clr = 1'b0;
        #1;
        check("rst_cnt", cnt_q, 16'h0000);
        check("rst_flags", {tick, busy, done}, 3'b000);
        check("rst_ticks", ticks, 8'd0);
        check("rst_idle_pins", {cnt_nclr, cnt_nload, cnt_enp, cnt_ent}, 4'b1100);

        // Periodic, PERIOD=5, PHASE=0
        period = 16'd5; phase = 4'd0; mode = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        check("per_arm_busy", busy, 1'b1);
        check("per_arm_nload", cnt_nload, 1'b0);
        step();
        check("per_load", cnt_q, 16'd0);
        check("per_ent", cnt_ent, 1'b1);
        for (int n = 1; n <= 15; n++) begin
            step();
            check($sformatf("per_cnt_%0d", n), cnt_q, 32'(n % 5));
            check($sformatf("per_tick_%0d", n), tick, (n % 5) == 0);
            check($sformatf("per_ticks_%0d", n), ticks, 32'(n / 5));
        end
        repeat (4) step();
        check("stop_at_term", cnt_q, 16'd4);
        stop = 1'b1;
        #1;
        check("stop_nclr", cnt_nclr, 1'b0);
        step();
        stop = 1'b0;
        check("stop_cnt", cnt_q, 16'd0);
        check("stop_flags", {tick, busy, done}, 3'b000);
        check("stop_ticks", ticks, 8'd3);

        // START with STOP in IDLE stays IDLE
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        #1;
        check("ss_busy", busy, 1'b0);
        check("ss_nload", cnt_nload, 1'b1);

        // One-shot, PERIOD=3, PHASE=1: term=2, tick three edges after arm
        period = 16'd3; phase = 4'd1; mode = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        check("os_din", cnt_din, 4'd1);
        step();
        check("os_load", cnt_q, 16'd1);
        step();
        check("os_term", cnt_q, 16'd2);
        check("os_pre_tick", {tick, busy, done}, 3'b010);
        step();
        check("os_tick", {tick, busy, done}, 3'b101);
        check("os_cnt0", cnt_q, 16'd0);
        check("os_ticks", ticks, 8'd1);
        step();
        check("os_after", {tick, busy, done}, 3'b001);
        check("os_held", cnt_q, 16'd0);
        check("os_enables", {cnt_enp, cnt_ent}, 2'b00);

        // Rearm from DONE: periodic PERIOD=4, PHASE=2, HOLD at term for 3 cycles
        period = 16'd4; phase = 4'd2; mode = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        check("re_arm", {busy, done}, 2'b10);
        check("re_ticks", ticks, 8'd0);
        step();
        check("re_load", cnt_q, 16'd2);
        step();
        check("re_term", cnt_q, 16'd3);
        hold = 1'b1;
        #1;
        check("hold_pins", {cnt_nclr, cnt_enp, cnt_ent}, 3'b101);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("hold_tick_%0d", i), tick, 1'b0);
            check($sformatf("hold_cnt_%0d", i), cnt_q, 16'd3);
        end
        hold = 1'b0;
        #1;
        check("unhold_nclr", cnt_nclr, 1'b0);
        step();
        check("unhold_tick", tick, 1'b1);
        check("unhold_cnt", cnt_q, 16'd0);
        check("unhold_ticks", ticks, 8'd1);
        repeat (3) step();
        check("p2_pre", {tick, cnt_q}, {1'b0, 16'd3});
        step();
        check("p2_tick", tick, 1'b1);
        check("p2_ticks", ticks, 8'd2);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("p2_stop", {busy, done}, 2'b00);

        // PERIOD=0: term=0xFFFF, first tick 65537 edges after arm
        period = 16'd0; phase = 4'd0; mode = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("p0_load", cnt_q, 16'd0);
        saw_tick = 1'b0;
        repeat (65535) begin
            step();
            saw_tick = saw_tick | tick;
        end
        check("p0_no_early_tick", saw_tick, 1'b0);
        check("p0_term", cnt_q, 16'hFFFF);
        step();
        check("p0_tick", {tick, busy, done}, 3'b101);
        check("p0_wrap", cnt_q, 16'h0000);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("p0_stop_idle", {tick, busy, done}, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
